// File: rtl/trap_sequencer.sv
// Commit-stage trap sequencer: selects one trap per commit by priority, issues a
// registered trap request, runs the flush handshake and raises a sticky fatal halt.
module trap_sequencer #(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_exc_valid,
  input  logic [4:0]  commit_exc_code,
  input  logic [31:0] commit_exc_tval,
  input  logic [2:0]  irq_pending,
  input  logic        sstatus_sie,
  input  logic        flush_done,
  output logic        commit_kill,
  output logic        trap_req,
  output logic [4:0]  trap_scause,
  output logic        trap_is_irq,
  output logic [31:0] trap_stval,
  output logic [31:0] trap_pc,
  output logic        flush_req,
  output logic        stall_commit,
  output logic        fatal
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [15:0] TIMEOUT_LAST = 16'(FLUSH_TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  localparam logic [4:0] CODE_SEI = 5'd9;
  localparam logic [4:0] CODE_SSI = 5'd1;
  localparam logic [4:0] CODE_STI = 5'd5;

  logic [1:0]  state_q, state_d;
  logic        entry_q, entry_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  scause_q, scause_d;
  logic        is_irq_q, is_irq_d;
  logic [31:0] stval_q, stval_d;
  logic [31:0] pc_q, pc_d;

  logic       irq_any;
  logic       take;
  logic [4:0] irq_code;

  assign irq_any = sstatus_sie && (|irq_pending);
  assign take    = commit_valid && (commit_exc_valid || irq_any);

  always_comb begin
    if (irq_pending[2])      irq_code = CODE_SEI;
    else if (irq_pending[1]) irq_code = CODE_SSI;
    else                     irq_code = CODE_STI;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    scause_d = scause_q;
    is_irq_d = is_irq_q;
    stval_d  = stval_q;
    pc_d     = pc_q;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (take) begin
          scause_d = irq_any ? irq_code : commit_exc_code;
          is_irq_d = irq_any;
          stval_d  = irq_any ? 32'd0 : commit_exc_tval;
          pc_d     = commit_pc;
          // An exception before the handler's first clean retire is unrecoverable.
          state_d  = (entry_q && !irq_any) ? HALT : ISSUE;
        end else if (commit_valid) begin
          entry_d = 1'b0;
        end
      end
      ISSUE: begin
        entry_d = 1'b1;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_done) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          if (cnt_q == TIMEOUT_LAST) state_d = HALT;
          if (cnt_q != CNT_MAX)      cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      entry_q  <= 1'b0;
      cnt_q    <= 16'd0;
      scause_q <= 5'd0;
      is_irq_q <= 1'b0;
      stval_q  <= 32'd0;
      pc_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      scause_q <= scause_d;
      is_irq_q <= is_irq_d;
      stval_q  <= stval_d;
      pc_q     <= pc_d;
    end
  end

  assign commit_kill  = (state_q == IDLE) && take;
  assign trap_req     = (state_q == ISSUE);
  assign flush_req    = (state_q == ISSUE) || (state_q == FLUSH);
  assign stall_commit = (state_q != IDLE);
  assign fatal        = (state_q == HALT);
  assign trap_scause  = scause_q;
  assign trap_is_irq  = is_irq_q;
  assign trap_stval   = stval_q;
  assign trap_pc      = pc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected traps go into a scoreboard queue and a
// monitor compares them whenever trap_req is seen; control outputs are checked inline.
module tb_trap_sequencer;

  typedef struct packed {
    logic [4:0]  scause;
    logic        is_irq;
    logic [31:0] stval;
    logic [31:0] pc;
  } trap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_exc_valid;
  logic [4:0]  commit_exc_code;
  logic [31:0] commit_exc_tval;
  logic [2:0]  irq_pending;
  logic        sstatus_sie;
  logic        flush_done;
  logic        commit_kill;
  logic        trap_req;
  logic [4:0]  trap_scause;
  logic        trap_is_irq;
  logic [31:0] trap_stval;
  logic [31:0] trap_pc;
  logic        flush_req;
  logic        stall_commit;
  logic        fatal;

  int checks = 0;
  int errors = 0;
  trap_t exp_q[$];

  trap_sequencer #(.FLUSH_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .commit_valid     (commit_valid),
    .commit_pc        (commit_pc),
    .commit_exc_valid (commit_exc_valid),
    .commit_exc_code  (commit_exc_code),
    .commit_exc_tval  (commit_exc_tval),
    .irq_pending      (irq_pending),
    .sstatus_sie      (sstatus_sie),
    .flush_done       (flush_done),
    .commit_kill      (commit_kill),
    .trap_req         (trap_req),
    .trap_scause      (trap_scause),
    .trap_is_irq      (trap_is_irq),
    .trap_stval       (trap_stval),
    .trap_pc          (trap_pc),
    .flush_req        (flush_req),
    .stall_commit     (stall_commit),
    .fatal            (fatal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every trap_req pulse must match the oldest expected trap.
  initial begin
    trap_t t;
    forever begin
      @(negedge clk);
      if (trap_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trap_req", 32'(trap_req), 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("trap_scause", 32'(trap_scause), 32'(t.scause));
          check("trap_is_irq", 32'(trap_is_irq), 32'(t.is_irq));
          check("trap_stval",  trap_stval,       t.stval);
          check("trap_pc",     trap_pc,          t.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    commit_valid     = 1'b0;
    commit_pc        = 32'd0;
    commit_exc_valid = 1'b0;
    commit_exc_code  = 5'd0;
    commit_exc_tval  = 32'd0;
    irq_pending      = 3'b000;
    sstatus_sie      = 1'b0;
    flush_done       = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic exc_v, input logic [4:0] code,
                        input logic [31:0] tval, input logic [2:0] irq, input logic sie);
    commit_valid     = 1'b1;
    commit_pc        = pc;
    commit_exc_valid = exc_v;
    commit_exc_code  = code;
    commit_exc_tval  = tval;
    irq_pending      = irq;
    sstatus_sie      = sie;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_trap_req"},     32'(trap_req),     32'd0);
    check({tag, "_flush_req"},    32'(flush_req),    32'd0);
    check({tag, "_stall_commit"}, 32'(stall_commit), 32'd0);
    check({tag, "_fatal"},        32'(fatal),        32'd0);
    check({tag, "_trap_is_irq"},  32'(trap_is_irq),  32'd0);
    check({tag, "_trap_scause"},  32'(trap_scause),  32'd0);
    check({tag, "_trap_stval"},   trap_stval,        32'd0);
    check({tag, "_trap_pc"},      trap_pc,           32'd0);
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Take at N, trap_req at N+1, flush_done at N+2, back in IDLE at N+3.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic exc_v,
                          input logic [4:0] code, input logic [31:0] tval,
                          input logic [2:0] irq, input logic sie,
                          input logic [4:0] e_cause, input logic e_irq, input logic [31:0] e_tval);
    commit(pc, exc_v, code, tval, irq, sie);
    #1 check({tag, "_kill"}, 32'(commit_kill), 32'd1);
    exp_q.push_back('{scause: e_cause, is_irq: e_irq, stval: e_tval, pc: pc});
    tick();
    clr_in();
    check({tag, "_issue_flush_req"}, 32'(flush_req),    32'd1);
    check({tag, "_issue_stall"},     32'(stall_commit), 32'd1);
    tick();
    flush_done = 1'b1;
    check({tag, "_flush_flush_req"}, 32'(flush_req),    32'd1);
    check({tag, "_flush_stall"},     32'(stall_commit), 32'd1);
    tick();
    flush_done = 1'b0;
    check({tag, "_idle_stall"},      32'(stall_commit), 32'd0);
    check({tag, "_idle_flush_req"},  32'(flush_req),    32'd0);
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    run_trap("load_pf", 32'h8000_0100, 1'b1, 5'd13, 32'h0000_2000, 3'b000, 1'b0,
             5'd13, 1'b0, 32'h0000_2000);

    // Clean retire clears the handler-entry flag.
    commit(32'h8000_0104, 1'b0, 5'd0, 32'd0, 3'b000, 1'b0);
    #1 check("clean_retire_kill", 32'(commit_kill), 32'd0);
    tick();
    clr_in();

    run_trap("irq_all", 32'h8000_0200, 1'b1, 5'd2, 32'h0000_dead, 3'b111, 1'b1,
             5'd9, 1'b1, 32'd0);
    // Flag is set here, but interrupts are still taken normally.
    run_trap("irq_ssi_sti", 32'h8000_0300, 1'b1, 5'd2, 32'h0000_beef, 3'b011, 1'b1,
             5'd1, 1'b1, 32'd0);

    commit(32'h8000_0400, 1'b0, 5'd0, 32'd0, 3'b111, 1'b0);
    #1 check("sie_gate_kill", 32'(commit_kill), 32'd0);
    tick();
    clr_in();
    check("sie_gate_stall", 32'(stall_commit), 32'd0);

    // flush_done on the 4th FLUSH cycle wins over the timeout.
    commit(32'h8000_0500, 1'b1, 5'd2, 32'h0000_1234, 3'b000, 1'b0);
    #1 check("late_flush_kill", 32'(commit_kill), 32'd1);
    exp_q.push_back('{scause: 5'd2, is_irq: 1'b0, stval: 32'h0000_1234, pc: 32'h8000_0500});
    tick();
    clr_in();
    repeat (4) tick();
    flush_done = 1'b1;
    check("late_flush_stall", 32'(stall_commit), 32'd1);
    tick();
    flush_done = 1'b0;
    check("late_flush_fatal", 32'(fatal),        32'd0);
    check("late_flush_idle",  32'(stall_commit), 32'd0);

    // Nested fault: first handler commit raises an exception.
    commit(32'h8000_0600, 1'b1, 5'd2, 32'h0000_0666, 3'b000, 1'b0);
    #1 check("nested_kill", 32'(commit_kill), 32'd1);
    tick();
    clr_in();
    check("nested_fatal",     32'(fatal),        32'd1);
    check("nested_stall",     32'(stall_commit), 32'd1);
    check("nested_flush_req", 32'(flush_req),    32'd0);
    commit(32'h8000_0604, 1'b1, 5'd3, 32'd0, 3'b111, 1'b1);
    #1 check("halt_kill", 32'(commit_kill), 32'd0);
    tick();
    clr_in();
    check("halt_sticky", 32'(fatal), 32'd1);
    do_reset();
    check_reset_vals("halt_rst");

    // Flush timeout: no flush_done, fatal after 4 FLUSH cycles.
    commit(32'h8000_0700, 1'b1, 5'd5, 32'h0000_0077, 3'b000, 1'b0);
    exp_q.push_back('{scause: 5'd5, is_irq: 1'b0, stval: 32'h0000_0077, pc: 32'h8000_0700});
    tick();
    clr_in();
    repeat (4) tick();
    check("timeout_pre_fatal", 32'(fatal), 32'd0);
    tick();
    check("timeout_fatal",     32'(fatal),        32'd1);
    check("timeout_flush_req", 32'(flush_req),    32'd0);
    check("timeout_stall",     32'(stall_commit), 32'd1);
    do_reset();

    // Reset while in FLUSH, then a fresh exception is taken normally.
    commit(32'h8000_0800, 1'b1, 5'd7, 32'h0000_0088, 3'b000, 1'b0);
    exp_q.push_back('{scause: 5'd7, is_irq: 1'b0, stval: 32'h0000_0088, pc: 32'h8000_0800});
    tick();
    clr_in();
    tick();
    check("midflush_in_flush", 32'(flush_req), 32'd1);
    do_reset();
    check_reset_vals("midflush_rst");
    run_trap("post_rst", 32'h8000_0900, 1'b1, 5'd4, 32'h0000_0099, 3'b000, 1'b0,
             5'd4, 1'b0, 32'h0000_0099);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Commit-stage trap sequencer. It sits directly upstream of the trap unit: it samples the exception and interrupt state of the instruction at commit and selects one trap by priority. It issues a single registered `trap_req` with cause, tval and faulting PC to the trap unit, then runs the pipeline flush handshake. It also detects nested faults and stalled flushes and reports them as a sticky fatal halt.

## Interface
- `FLUSH_TIMEOUT`, default 64: maximum cycles spent in FLUSH before a fatal halt; legal range 2..65535.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `commit_valid` input 1: an instruction is presented at commit this cycle.
- `commit_pc` input 32: PC of the committing instruction.
- `commit_exc_valid` input 1: the committing instruction raised a synchronous exception. Qualified by `commit_valid`.
- `commit_exc_code` input 5: exception cause code.
- `commit_exc_tval` input 32: exception tval.
- `irq_pending` input 3: {SEI, SSI, STI}, already masked by sie.
- `sstatus_sie` input 1: global supervisor interrupt enable.
- `flush_done` input 1: the pipeline has drained after a flush request.
- `commit_kill` output 1: combinational. Suppresses retirement of the current commit because a trap is being taken.
- `trap_req` output 1: one-cycle trap pulse to the trap unit.
- `trap_scause` output 5: cause code; valid with `trap_req`.
- `trap_is_irq` output 1: marks the trap as an interrupt, i.e. the scause interrupt bit.
- `trap_stval` output 32: tval; 0 for interrupts.
- `trap_pc` output 32: PC to be written to sepc.
- `flush_req` output 1: asks the pipeline to flush. Held until accepted.
- `stall_commit` output 1: commit must hold while this is high.
- `fatal` output 1: sticky fatal halt.

## Operation
- FSM states: IDLE, ISSUE, FLUSH, HALT. Reset state is IDLE.
- **Take condition (IDLE only):** `take = commit_valid && (commit_exc_valid || irq_any)`, where `irq_any = sstatus_sie && |irq_pending`.
- **Priority:** interrupts beat exceptions on the same instruction. Among interrupts, SEI (code 9) > SSI (1) > STI (5).
- **Interrupt trap:** `trap_is_irq`=1, `trap_stval`=0.
- **Exception trap:** `trap_is_irq`=0; scause and stval are taken from `commit_exc_code` and `commit_exc_tval`.
- **`trap_pc`** is always `commit_pc`. The instruction is not retired in either case.
- **`commit_kill`** = `take` while in IDLE; 0 in every other state.
- **IDLE → ISSUE on `take`:** cause, tval, irq flag and PC are registered into the output holding registers.
- **Nested-fault check:** if the handler-entry flag is set and the selected trap is an exception (not an interrupt), go to HALT instead of ISSUE.
  - No `trap_req` is issued and `fatal` rises.
  - `commit_kill` still asserts on that cycle.
- **ISSUE (exactly 1 cycle):**
  - `trap_req`=1.
  - The handler-entry flag is set.
  - Next state is FLUSH.
- **FLUSH:**
  - The timeout counter increments each cycle.
  - `flush_done`=1 → IDLE and the counter clears. `flush_done` is ignored in ISSUE.
  - If the counter reaches FLUSH_TIMEOUT-1 with `flush_done` low → HALT.
  - If `flush_done` arrives on the same cycle the counter reaches FLUSH_TIMEOUT-1, `flush_done` wins and the next state is IDLE.
- **HALT:**
  - Terminal until `rst`.
  - `fatal`=1, `stall_commit`=1; no `trap_req` and no `commit_kill`.
- **Handler-entry flag:**
  - Cleared when, in IDLE, `commit_valid` && !`commit_exc_valid` && !`irq_any`, i.e. a clean retire.
  - While the flag is set, interrupts are still taken normally. Only an exception before the first clean retire is fatal.
- **Non-IDLE states:** all commit and interrupt inputs are ignored.
- **Holding registers** (`trap_scause`, `trap_stval`, `trap_pc`, `trap_is_irq`) keep their value until the next trap is captured.
- **Counter width:** 16 bits; it saturates and does not wrap.

## Timing
- **Reset values:** `trap_req`, `trap_is_irq`, `flush_req`, `stall_commit`, `fatal` = 0; `trap_scause`=0; `trap_stval`=0; `trap_pc`=0. Flag and counter are 0.
- `rst` mid-operation from any state, HALT included, returns to IDLE on the next edge with the reset values above.
- **Latency:** a take in cycle N gives `commit_kill` in cycle N and `trap_req` in cycle N+1. `flush_req` is high from N+1 until the cycle `flush_done` is seen in FLUSH, inclusive.
- `stall_commit` = registered (state != IDLE): high from N+1 through the cycle that `flush_done` is accepted. It is low on the first IDLE cycle after that.
- The earliest possible back-to-back take is cycle N+3, when `flush_done` is high at N+2.
- `flush_req` and `stall_commit` are decoded from the registered state, so they carry no combinational path from inputs.

## Test plan
- **Load page fault:** commit of pc=0x8000_0100 with exc code 13, tval 0x0000_2000 → `commit_kill` at N; at N+1 `trap_req`=1, scause=13, stval=0x2000, `trap_pc`=0x8000_0100, `trap_is_irq`=0; `flush_done` at N+2 → IDLE at N+3.
- **Interrupt vs exception:** `irq_pending`=3'b111, sie=1, simultaneous exception code 2 → scause=9, `trap_is_irq`=1, stval=0. Repeating with SSI+STI only gives scause=1.
- **Interrupt gating:** sie=0 with irq pending and no exception → no `commit_kill`, no trap, instruction retires.
- **Nested fault:** trap taken and flushed, then the first commit at the handler raises exc code 2 → HALT. `fatal`=1, `trap_req` stays 0, `stall_commit`=1; `rst` clears all.
- **Flush timeout:** FLUSH_TIMEOUT=4, `flush_done` never arrives → `fatal` after 4 FLUSH cycles. Repeating with `flush_done` on the 4th FLUSH cycle → IDLE, no `fatal`.
- **Mid-flush reset:** assert `rst` while in FLUSH → next cycle all outputs at reset values, and a new exception is taken normally.
